// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencing controller for the RV32I datapath: fetch, decode, data access, trap.
// Optional handshake watchdog is built when CTRL_WDOG_EN is defined.
module core_ctrl_fsm #(
  parameter int WDOG_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  input  logic        zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        pcsrc,
  output logic        ALUSrc,
  output logic        reg_write,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUCtrl,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instret
);
  // state | meaning
  // FETCH | request instruction, latch it on imem_ready
  // EXEC  | decode Instr, retire ALU/branch/jal, or hand off to MEM
  // MEM   | hold address controls until dmem_ready, then retire lw/sw
  // TRAP  | unsupported encoding or watchdog expiry; wait for reset
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instret_q;
  logic        illegal_q, timeout_q;
  logic        instr_ld, set_illegal, set_timeout, wd_hit;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        is_r, is_i, is_br, is_jal, is_lw, is_sw;
  logic [3:0]  alu_op;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign f7b5   = instr_q[30];

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_br  = (opcode == OP_B) && (funct3[2:1] == 2'b00);
  assign is_jal = (opcode == OP_JAL);
  assign is_lw  = (opcode == OP_LD) && (funct3 == 3'b010);
  assign is_sw  = (opcode == OP_ST) && (funct3 == 3'b010);

  // funct7[5] only distinguishes SUB for R-type; shifts honour it in both formats
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_en       = 1'b0;
    pcsrc       = 1'b0;
    ALUSrc      = 1'b0;
    reg_write   = 1'b0;
    ResultSrc   = 2'b00;
    ImmSrc      = 2'b00;
    ALUCtrl     = ALU_ADD;
    instr_ld    = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (wd_hit) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end else if (imem_ready) begin
          instr_ld = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          reg_write = 1'b1;
          ALUCtrl   = alu_op;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end else if (is_i) begin
          ALUSrc    = 1'b1;
          reg_write = 1'b1;
          ALUCtrl   = alu_op;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end else if (is_br) begin
          ImmSrc  = 2'b10;
          ALUCtrl = ALU_SUB;
          pcsrc   = zero ^ funct3[0];
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          ImmSrc    = 2'b11;
          pcsrc     = 1'b1;
          reg_write = 1'b1;
          ResultSrc = 2'b10;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end else if (is_lw || is_sw) begin
          ALUSrc  = 1'b1;
          ImmSrc  = is_sw ? 2'b01 : 2'b00;
          state_d = S_MEM;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        ImmSrc   = is_sw ? 2'b01 : 2'b00;
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (wd_hit) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end else if (dmem_ready) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
          if (is_lw) begin
            reg_write = 1'b1;
            ResultSrc = 2'b01;
          end
        end
      end
      default: ;
    endcase
    // reset aborts any handshake in flight within the same cycle
    if (reset) begin
      state_d     = S_FETCH;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      pc_en       = 1'b0;
      pcsrc       = 1'b0;
      ALUSrc      = 1'b0;
      reg_write   = 1'b0;
      ResultSrc   = 2'b00;
      ImmSrc      = 2'b00;
      ALUCtrl     = ALU_ADD;
      instr_ld    = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_q   <= 32'h0000_0013;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_ld)    instr_q   <= imem_rdata;
      if (pc_en)       instret_q <= instret_q + 32'd1;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

`ifdef CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] WD_LIM = CW'(WDOG_CYCLES);
  logic [CW-1:0] wd_cnt;

  assign wd_hit = ((state_q == S_FETCH) || (state_q == S_MEM)) && (wd_cnt == WD_LIM);

  always_ff @(posedge clk) begin
    if (reset || (state_d != state_q))
      wd_cnt <= '0;
    else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready))
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign Instr   = instr_q;
  assign instret = instret_q;
  assign illegal = illegal_q & ~reset;
  assign timeout = timeout_q & ~reset;
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: random instruction stream with random handshake waits,
// expected retire behaviour derived from each generated mnemonic, plus directed trap/reset cases.
module tb_core_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata, Instr;
  logic        zero;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        pc_en, pcsrc, ALUSrc, reg_write;
  logic [1:0]  ResultSrc, ImmSrc;
  logic [3:0]  ALUCtrl;
  logic        illegal, timeout;
  logic [31:0] instret;

  core_ctrl_fsm #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instr(Instr), .zero(zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pcsrc(pcsrc), .ALUSrc(ALUSrc), .reg_write(reg_write),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUCtrl(ALUCtrl),
    .illegal(illegal), .timeout(timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic [12:0] ctrl;
    int          ret_cyc;
    int          seq;
    bit          mem;
    bit          st;
    int          dwait;
  } exp_t;

  exp_t sbq[$];
  int   seq = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // kinds: 0-9 R ops, 10-18 I ops, 19 beq, 20 bne, 21 jal, 22 lw, 23 sw
  function automatic void op_info(input int k, output logic [2:0] f3, output bit b30, output logic [3:0] a);
    b30 = 1'b0;
    case (k)
      0:  begin f3 = 3'b000; a = 4'd0; end              // add
      1:  begin f3 = 3'b000; a = 4'd1; b30 = 1'b1; end  // sub
      2:  begin f3 = 3'b001; a = 4'd6; end              // sll
      3:  begin f3 = 3'b010; a = 4'd5; end              // slt
      4:  begin f3 = 3'b011; a = 4'd9; end              // sltu
      5:  begin f3 = 3'b100; a = 4'd4; end              // xor
      6:  begin f3 = 3'b101; a = 4'd7; end              // srl
      7:  begin f3 = 3'b101; a = 4'd8; b30 = 1'b1; end  // sra
      8:  begin f3 = 3'b110; a = 4'd3; end              // or
      9:  begin f3 = 3'b111; a = 4'd2; end              // and
      10: begin f3 = 3'b000; a = 4'd0; end              // addi
      11: begin f3 = 3'b010; a = 4'd5; end              // slti
      12: begin f3 = 3'b011; a = 4'd9; end              // sltiu
      13: begin f3 = 3'b100; a = 4'd4; end              // xori
      14: begin f3 = 3'b110; a = 4'd3; end              // ori
      15: begin f3 = 3'b111; a = 4'd2; end              // andi
      16: begin f3 = 3'b001; a = 4'd6; end              // slli
      17: begin f3 = 3'b101; a = 4'd7; end              // srli
      18: begin f3 = 3'b101; a = 4'd8; b30 = 1'b1; end  // srai
      default: begin f3 = 3'b000; a = 4'd0; end
    endcase
  endfunction

  function automatic logic [31:0] build(input int k);
    logic [31:0] r;
    logic [2:0]  f3;
    bit          b30;
    logic [3:0]  a;
    r = $urandom;
    op_info(k, f3, b30, a);
    if (k <= 9)                     return {1'b0, b30, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
    if (k == 16 || k == 17 || k == 18) return {1'b0, b30, 5'b0, r[24:15], f3, r[11:7], 7'b0010011};
    if (k <= 15)                    return {r[31:15], f3, r[11:7], 7'b0010011};
    if (k == 19)                    return {r[31:15], 3'b000, r[11:7], 7'b1100011};
    if (k == 20)                    return {r[31:15], 3'b001, r[11:7], 7'b1100011};
    if (k == 21)                    return {r[31:7], 7'b1101111};
    if (k == 22)                    return {r[31:15], 3'b010, r[11:7], 7'b0000011};
    return {r[31:15], 3'b010, r[11:7], 7'b0100011};
  endfunction

  // retire-cycle controls: {pcsrc, reg_write, ResultSrc, ImmSrc, ALUSrc, ALUCtrl, dmem_req, dmem_we}
  function automatic logic [12:0] ctrl_of(input int k, input bit z);
    logic [2:0] f3;
    bit b30, pcs, rw, als, dr, dw;
    logic [1:0] rs, im;
    logic [3:0] a;
    op_info(k, f3, b30, a);
    pcs = 0; rw = 0; als = 0; dr = 0; dw = 0; rs = 2'b00; im = 2'b00;
    if (k <= 9)       begin rw = 1; end
    else if (k <= 18) begin rw = 1; als = 1; end
    else if (k == 19) begin im = 2'b10; a = 4'd1; pcs = z; end
    else if (k == 20) begin im = 2'b10; a = 4'd1; pcs = !z; end
    else if (k == 21) begin im = 2'b11; a = 4'd0; pcs = 1; rw = 1; rs = 2'b10; end
    else if (k == 22) begin als = 1; a = 4'd0; rw = 1; rs = 2'b01; dr = 1; end
    else              begin als = 1; a = 4'd0; im = 2'b01; dr = 1; dw = 1; end
    return {pcs, rw, rs, im, als, a, dr, dw};
  endfunction

  task automatic run_instr(input int k, input logic [31:0] ins, input int iwait, input int dwait, input bit z);
    exp_t e;
    bit   mem;
    mem = (k >= 22);
    imem_ready = 1'b0;
    repeat (iwait) begin
      check("imem_req_during_wait", imem_req, 1);
      dmem_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = ins;
    zero       = z;
    e.instr   = ins;
    e.ctrl    = ctrl_of(k, z);
    e.mem     = mem;
    e.st      = (k == 23);
    e.dwait   = dwait;
    e.seq     = seq;
    e.ret_cyc = cyc + 1 + (mem ? dwait + 1 : 0);
    seq++;
    sbq.push_back(e);
    @(posedge clk); #1;
    imem_ready = $urandom_range(0, 1);
    imem_rdata = $urandom;
    dmem_ready = $urandom_range(0, 1);
    @(posedge clk); #1;
    zero = $urandom_range(0, 1);
    if (mem) begin
      dmem_ready = 1'b0;
      repeat (dwait) begin
        imem_ready = $urandom_range(0, 1);
        @(posedge clk); #1;
      end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
    imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    seq = 0;
    #1;
  endtask

  // monitor: pops the scoreboard whenever the DUT retires
  int mem_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_cnt = 0;
      end else begin
        check("rw_implies_pc_en", {31'd0, reg_write & ~pc_en}, 0);
        if (dmem_req) begin
          mem_cnt++;
          if (sbq.size() == 0) check("dmem_req_unexpected", dmem_req, 0);
          else begin
            check("dmem_we", dmem_we, sbq[0].st);
            check("mem_instr_stable", Instr, sbq[0].instr);
          end
        end
        if (pc_en) begin
          if (sbq.size() == 0) check("retire_unexpected", pc_en, 0);
          else begin
            e = sbq.pop_front();
            check("retire_ctrl", {pcsrc, reg_write, ResultSrc, ImmSrc, ALUSrc, ALUCtrl, dmem_req, dmem_we}, e.ctrl);
            check("retire_cycle", cyc, e.ret_cyc);
            check("retire_instr", Instr, e.instr);
            check("instret", instret, e.seq);
            if (e.mem) check("mem_req_cycles", mem_cnt, e.dwait + 1);
            mem_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] bad [3];
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; zero = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_imem_req", imem_req, 0);
    check("reset_pc_en", pc_en, 0);
    do_reset();
    check("post_reset_imem_req", imem_req, 1);
    check("post_reset_instr", Instr, 32'h0000_0013);
    check("post_reset_instret", instret, 0);
    check("post_reset_illegal", illegal, 0);
    check("post_reset_timeout", timeout, 0);

    run_instr(0, 32'h002081B3, 0, 0, 1'b0);  // add x3,x1,x2
    check("add_instret", instret, 1);
    run_instr(22, 32'h00802283, 0, 3, 1'b0); // lw x5,8(x0) with 3 wait cycles
    run_instr(19, 32'h00000463, 0, 0, 1'b1); // beq taken
    run_instr(19, 32'h00000463, 1, 0, 1'b0); // beq not taken
    run_instr(20, 32'h00001463, 2, 0, 1'b0); // bne taken
    run_instr(23, 32'h0062A023, 0, 0, 1'b0); // sw zero-wait

    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 23);
      run_instr(k, build(k), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", sbq.size(), 0);

    // reset in the second MEM cycle of a store
    imem_ready = 1'b1; imem_rdata = 32'h0062A023;
    sbq.push_back('{instr: 32'h0062A023, ctrl: ctrl_of(23, 0), ret_cyc: -1, seq: seq, mem: 1, st: 1, dwait: 99});
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    check("sw_mem1_dmem_req", dmem_req, 1);
    check("sw_mem1_dmem_we", dmem_we, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_aborts_dmem_req", dmem_req, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    seq = 0;
    #1;
    check("abort_imem_req", imem_req, 1);
    check("abort_instr_nop", Instr, 32'h0000_0013);
    check("abort_instret", instret, 0);

    // unsupported encodings: all-zero, lb, blt
    bad[0] = 32'h0000_0000; bad[1] = 32'h0000_0003; bad[2] = 32'h0000_4063;
    for (int b = 0; b < 3; b++) begin
      imem_ready = 1'b1; imem_rdata = bad[b];
      @(posedge clk); #1;
      imem_ready = 1'b0;
      check("illegal_exec_pc_en", pc_en, 0);
      @(posedge clk); #1;
      check("illegal_flag", illegal, 1);
      for (int c = 0; c < 20; c++) begin
        imem_ready = $urandom_range(0, 1);
        dmem_ready = $urandom_range(0, 1);
        #1;
        check("trap_quiet", {28'd0, imem_req, pc_en, dmem_req, reg_write}, 0);
        @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check("illegal_forced_low_in_reset", illegal, 0);
      do_reset();
      check("illegal_cleared", illegal, 0);
      check("trap_exit_imem_req", imem_req, 1);
    end

    // fetch stall with imem_ready held low
    imem_ready = 1'b0;
`ifdef CTRL_WDOG_EN
    begin
      int waited;
      waited = 0;
      while (!timeout && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      check("wdog_timeout", timeout, 1);
      check("wdog_imem_req_drops", imem_req, 0);
      do_reset();
    end
`else
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("stall_imem_req", imem_req, 1);
      check("stall_timeout", timeout, 0);
    end
    do_reset();
`endif

    run_instr(10, build(10), 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_ctrl_fsm.md
# core_ctrl_fsm

Multi-cycle sequencing controller for the RV32I single-cycle datapath core. It fetches each instruction over a valid/ready instruction-memory handshake and holds it in an internal instruction register. It decodes the instruction, drives every datapath control input, and stalls PC update and register write-back until any data-memory access completes. It also counts retired instructions and traps on unsupported encodings.

## Interface

Parameters:
- WDOG_CYCLES, 16: handshake watchdog limit in cycles. Used only when CTRL_WDOG_EN is defined.

Ports:
- clk  in  1  rising-edge clock, the single clock domain.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- Instr  out  32  instruction register, driven to the datapath.
- zero  in  1  ALU zero flag from the datapath.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when 1, load when 0. Meaningful only while dmem_req is 1.
- dmem_ready  in  1  data access complete; load data is valid this cycle.
- pc_en  out  1  PC register load enable (the datapath gates pc_reg with it).
- pcsrc  out  1  0 selects PC+4, 1 selects PC target.
- ALUSrc  out  1  0 selects rs2, 1 selects ImmExt.
- reg_write  out  1  register file write enable.
- ResultSrc  out  2  00 ALU result, 01 ReadData, 10 PC+4.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- ALUCtrl  out  4  ALU operation code (encoding under Operation).
- illegal  out  1  sticky trap flag.
- timeout  out  1  sticky watchdog trap flag. Always 0 without CTRL_WDOG_EN.
- instret  out  32  retired-instruction counter.

## Operation

States: FETCH, EXEC, MEM, TRAP.

FETCH:
- imem_req=1.
- When imem_ready=1, Instr<=imem_rdata and the next state is EXEC. Otherwise stay in FETCH.

EXEC: decode opcode=Instr[6:0] and funct3=Instr[14:12]. All decode is combinational from the registered Instr.
- 0110011 (R-type): ALUSrc=0, reg_write=1, ResultSrc=00, pc_en=1, next state FETCH.
- 0010011 (I-type ALU): ALUSrc=1, ImmSrc=00, reg_write=1, pc_en=1, next state FETCH.
- 1100011 (branch), funct3 000 (beq) or 001 (bne): ImmSrc=10, ALUCtrl=SUB, pcsrc=zero XOR funct3[0], pc_en=1, next state FETCH.
- 1101111 (jal): ImmSrc=11, pcsrc=1, reg_write=1, ResultSrc=10, pc_en=1, next state FETCH.
- 0000011 with funct3=010 (lw): ALUSrc=1, ImmSrc=00, ALUCtrl=ADD, next state MEM.
- 0100011 with funct3=010 (sw): ALUSrc=1, ImmSrc=01, ALUCtrl=ADD, next state MEM.
- Any other encoding: illegal<=1, next state TRAP.

MEM:
- ALUSrc, ImmSrc and ALUCtrl are held from EXEC. dmem_req=1, dmem_we=1 for sw.
- When dmem_ready=1:
  - lw: reg_write=1, ResultSrc=01.
  - Both lw and sw: pc_en=1, next state FETCH.

TRAP:
- All enables are 0. The controller stays in TRAP until reset.

ALUCtrl encoding:
- R-type uses funct3 with funct7[5]; I-type ALU uses funct3, with funct7[5] applied only for shifts.
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
- SUB is selected only for R-type with funct7[5]=1.

instret:
- Increments by 1 on every cycle where pc_en=1.
- Wraps from 0xFFFFFFFF to 0.

Default output values: any output not listed for a state is 0.

## Timing

- Reset values: state=FETCH, Instr=32'h00000013 (NOP), illegal=0, timeout=0, instret=0.
- While reset=1, every output except Instr and instret is forced to 0 combinationally. This includes a reset asserted mid-MEM: the access is aborted and dmem_req is 0 in the reset cycle.
- Outputs are combinational from state, Instr and the handshake inputs. The state register, Instr, instret and the flags update on the clk edge.
- Latency with zero-wait memory:
  - ALU, branch and jal instructions: 2 cycles (FETCH, EXEC).
  - lw and sw: 3 cycles.
  - Each wait cycle (ready=0) adds one cycle. The request stays asserted and Instr stays stable throughout.
- imem_ready is ignored outside FETCH. dmem_ready is ignored outside MEM.
- pc_en and reg_write are each asserted for exactly one cycle per retired instruction.

## Configuration

- CTRL_WDOG_EN defined:
  - A counter clears on entry to FETCH or MEM and increments on each cycle where imem_req or dmem_req is high with ready low.
  - When the counter reaches WDOG_CYCLES, timeout<=1 and the next state is TRAP.
  - A ready arriving in that same cycle loses to the timeout.
- CTRL_WDOG_EN undefined:
  - No counter is built, timeout is tied to 0, and handshakes wait indefinitely.

## Test plan

- add x3,x1,x2 (0x002081B3) with imem_ready=1 immediately -> the EXEC cycle shows ALUCtrl=0000, ALUSrc=0, reg_write=1, pc_en=1; instret=1 after 2 cycles.
- lw x5,8(x0) (0x00802283) with dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles; reg_write=1 and ResultSrc=01 only in the ready cycle.
- beq (0x00000463) with zero=1 -> pcsrc=1, ImmSrc=10, ALUCtrl=0001. Same with zero=0 -> pcsrc=0. bne (0x00001463) with zero=0 -> pcsrc=1.
- Fetch 0x00000000 -> illegal=1 and state TRAP; pc_en and imem_req stay 0 for 20 further cycles; reset clears illegal.
- With CTRL_WDOG_EN and WDOG_CYCLES=16, imem_ready held at 0 -> timeout=1 after 16 cycles and imem_req drops. Without the macro, imem_req stays 1.
- sw x6,0(x5) (0x0062A023) with reset asserted in the second MEM cycle -> dmem_req=0 in the reset cycle; FETCH with Instr=0x00000013 and instret=0 follows.
